fb_hazard_ctrl: RTL and testbench

FB_HAZARD_CTRL -- requirements
Module: fb_hazard_ctrl

---
 rtl/fb_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_fb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a
// multi-cycle-unit freeze with timeout, plus a saturating stall counter.
module fb_hazard_ctrl #(
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_reg_write_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_branch_taken_i,
   input  logic             ex_mc_op_i,
   input  logic             mc_done_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_we_o,
   output logic             idex_lock_o,
   output logic             mc_start_o,
   output logic             mc_error_o,
   output logic [CNT_W-1:0] stall_count_o
);

   localparam int unsigned WCNT_W = (MC_TIMEOUT < 1) ? 1 : $clog2(MC_TIMEOUT + 1);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MC_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                mc_error_q, mc_error_d;
   logic [CNT_W-1:0]    stall_q, stall_d;

   logic load_use;
   logic timeout;
   logic pc_we, ifid_we, ifid_flush, idex_we, idex_lock, mc_start;

   // Write-enable of the EX instruction does not affect hazard decisions.
   logic unused_reg_write;
   assign unused_reg_write = ex_reg_write_i;

   assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
   assign timeout  = (wcnt_q == WCNT_W'(MC_TIMEOUT));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_RUN;
         wcnt_q     <= '0;
         mc_error_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         mc_error_q <= mc_error_d;
         stall_q    <= stall_d;
      end
   end

   // Next-state and Mealy enables; branch > multi-cycle > load-use in RUN.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      mc_error_d = mc_error_q;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      idex_we    = 1'b1;
      idex_lock  = 1'b0;
      mc_start   = 1'b0;

      case (state_q)
         ST_RUN: begin
            wcnt_d = '0;
            if (ex_branch_taken_i) begin
               ifid_flush = 1'b1;
               idex_lock  = 1'b1;
            end else if (ex_mc_op_i) begin
               mc_start = 1'b1;
               pc_we    = 1'b0;
               ifid_we  = 1'b0;
               idex_we  = 1'b0;
               state_d  = ST_MC_WAIT;
            end else if (load_use) begin
               pc_we     = 1'b0;
               ifid_we   = 1'b0;
               idex_lock = 1'b1;
            end
         end
         ST_MC_WAIT: begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            if (mc_done_i) begin
               state_d = ST_RUN;
            end else if (timeout) begin
               state_d    = ST_RUN;
               mc_error_d = 1'b1;
            end else begin
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               idex_we = 1'b0;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Outputs park in a safe bubble-inserting pattern while reset is held.
      if (!rst_n_i) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         ifid_flush = 1'b0;
         idex_we    = 1'b0;
         idex_lock  = 1'b1;
         mc_start   = 1'b0;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_comb begin
      stall_d = stall_q;
      if (!pc_we && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   assign pc_we_o       = pc_we;
   assign ifid_we_o     = ifid_we;
   assign ifid_flush_o  = ifid_flush;
   assign idex_we_o     = idex_we;
   assign idex_lock_o   = idex_lock;
   assign mc_start_o    = mc_start;
   assign mc_error_o    = mc_error_q;
   assign stall_count_o = stall_q;

endmodule

// File: tb/tb_fb_hazard_ctrl.sv
// Directed bench for fb_hazard_ctrl: instance A uses default parameters,
// instance B uses MC_TIMEOUT=4 and a 3-bit stall counter.
module tb_fb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       mr;
      logic       rw;
      logic [4:0] rd;
      logic       br;
      logic       mc;
      logic       done;
   } in_t;

   typedef struct {
      in_t        in;
      logic [5:0] exp_o;
      int         exp_stall;
   } vec_t;

   // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_lock, mc_start}
   localparam logic [5:0] O_IDLE  = 6'b110100;
   localparam logic [5:0] O_LU    = 6'b000110;
   localparam logic [5:0] O_BR    = 6'b111110;
   localparam logic [5:0] O_FRZ   = 6'b000000;
   localparam logic [5:0] O_START = 6'b000001;
   localparam logic [5:0] O_RST   = 6'b000010;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write;
   logic ex_branch_taken, ex_mc_op, mc_done;

   logic a_pc, a_ifid, a_flush, a_idex, a_lock, a_start, a_err;
   logic [15:0] a_stall;
   logic b_pc, b_ifid, b_flush, b_idex, b_lock, b_start, b_err;
   logic [2:0] b_stall;

   int total = 0;
   int passed = 0;
   int starts;

   always #5 clk = ~clk;

   fb_hazard_ctrl dut_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
      .ex_rd_i(ex_rd), .ex_branch_taken_i(ex_branch_taken),
      .ex_mc_op_i(ex_mc_op), .mc_done_i(mc_done),
      .pc_we_o(a_pc), .ifid_we_o(a_ifid), .ifid_flush_o(a_flush),
      .idex_we_o(a_idex), .idex_lock_o(a_lock), .mc_start_o(a_start),
      .mc_error_o(a_err), .stall_count_o(a_stall)
   );

   fb_hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(3)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .ex_mem_read_i(ex_mem_read), .ex_reg_write_i(ex_reg_write),
      .ex_rd_i(ex_rd), .ex_branch_taken_i(ex_branch_taken),
      .ex_mc_op_i(ex_mc_op), .mc_done_i(mc_done),
      .pc_we_o(b_pc), .ifid_we_o(b_ifid), .ifid_flush_o(b_flush),
      .idex_we_o(b_idex), .idex_lock_o(b_lock), .mc_start_o(b_start),
      .mc_error_o(b_err), .stall_count_o(b_stall)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic drive(input in_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2;
      id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
      ex_mem_read = v.mr; ex_reg_write = v.rw; ex_rd = v.rd;
      ex_branch_taken = v.br; ex_mc_op = v.mc; mc_done = v.done;
   endtask

   function automatic in_t mk(input logic mc, input logic done);
      in_t v;
      v = '0;
      v.mc = mc;
      v.done = done;
      return v;
   endfunction

   // Called at posedge+1: drive, check Mealy outputs mid-cycle, advance to next posedge+1.
   task automatic cyc(input in_t v, input logic use_b, input logic [5:0] exp, input string nm);
      logic [5:0] a_o, b_o;
      drive(v);
      #3;
      a_o = {a_pc, a_ifid, a_flush, a_idex, a_lock, a_start};
      b_o = {b_pc, b_ifid, b_flush, b_idex, b_lock, b_start};
      chk(nm, 32'(use_b ? b_o : a_o), 32'(exp));
      if (use_b ? b_start : a_start) starts++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive('0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[10];

   initial begin
      // {rs1, rs2, u1, u2, mr, rw, rd, br, mc, done}
      tbl[0] = '{in_t'{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}, O_IDLE, 0};
      tbl[1] = '{in_t'{5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0}, O_LU,   1};
      tbl[2] = '{in_t'{5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}, O_IDLE, 1};
      tbl[3] = '{in_t'{5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0}, O_IDLE, 1};
      tbl[4] = '{in_t'{5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0}, O_LU,   2};
      tbl[5] = '{in_t'{5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0}, O_LU,   3};
      tbl[6] = '{in_t'{5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0}, O_IDLE, 3};
      tbl[7] = '{in_t'{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0}, O_BR,   3};
      tbl[8] = '{in_t'{5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0}, O_BR,   3};
      tbl[9] = '{in_t'{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}, O_IDLE, 3};

      drive('0);
      rst_n = 1'b0;
      #12;
      chk("reset_outputs", 32'({a_pc, a_ifid, a_flush, a_idex, a_lock, a_start}), 32'(O_RST));
      chk("reset_stall", 32'(a_stall), 32'd0);
      chk("reset_err", 32'(a_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].in, 1'b0, tbl[i].exp_o, $sformatf("vec%0d_outputs", i));
         chk($sformatf("vec%0d_stall", i), 32'(a_stall), 32'(tbl[i].exp_stall));
      end

      // Multi-cycle op with mc_done ten cycles after the start pulse.
      starts = 0;
      cyc(mk(1'b1, 1'b0), 1'b0, O_START, "mc_entry");
      for (int k = 1; k <= 9; k++) cyc(mk(1'b1, 1'b0), 1'b0, O_FRZ, $sformatf("mc_wait%0d", k));
      cyc(mk(1'b1, 1'b1), 1'b0, O_IDLE, "mc_done_exit");
      cyc(mk(1'b0, 1'b0), 1'b0, O_IDLE, "mc_back_run");
      chk("mc_start_pulses", 32'(starts), 32'd1);
      chk("mc_stall", 32'(a_stall), 32'd13);
      chk("mc_no_error", 32'(a_err), 32'd0);

      // Timeout tie on B: mc_done in the timeout cycle is a normal exit.
      do_reset();
      cyc(mk(1'b1, 1'b0), 1'b1, O_START, "tie_entry");
      for (int k = 1; k <= 4; k++) cyc(mk(1'b0, 1'b0), 1'b1, O_FRZ, $sformatf("tie_wait%0d", k));
      cyc(mk(1'b0, 1'b1), 1'b1, O_IDLE, "tie_exit");
      chk("tie_no_error", 32'(b_err), 32'd0);
      chk("tie_stall", 32'(b_stall), 32'd5);

      // Timeout on B: mc_done never arrives.
      do_reset();
      starts = 0;
      cyc(mk(1'b1, 1'b0), 1'b1, O_START, "to_entry");
      for (int k = 1; k <= 4; k++) cyc(mk(1'b0, 1'b0), 1'b1, O_FRZ, $sformatf("to_wait%0d", k));
      chk("to_err_before", 32'(b_err), 32'd0);
      cyc(mk(1'b0, 1'b0), 1'b1, O_IDLE, "to_release");
      chk("to_err_set", 32'(b_err), 32'd1);
      chk("to_stall", 32'(b_stall), 32'd5);
      cyc(mk(1'b0, 1'b0), 1'b1, O_IDLE, "to_idle");
      chk("to_err_held", 32'(b_err), 32'd1);

      // Following normal op on B completes; stall counter saturates at 7.
      cyc(mk(1'b1, 1'b0), 1'b1, O_START, "post_entry");
      cyc(mk(1'b1, 1'b0), 1'b1, O_FRZ, "post_wait1");
      cyc(mk(1'b1, 1'b0), 1'b1, O_FRZ, "post_wait2");
      cyc(mk(1'b1, 1'b1), 1'b1, O_IDLE, "post_exit");
      cyc(mk(1'b0, 1'b0), 1'b1, O_IDLE, "post_run");
      chk("post_starts", 32'(starts), 32'd2);
      chk("post_stall_sat", 32'(b_stall), 32'd7);
      chk("post_err_held", 32'(b_err), 32'd1);

      // Reset asserted during MC_WAIT cycle 3 on A.
      do_reset();
      cyc(mk(1'b1, 1'b0), 1'b0, O_START, "rst_entry");
      cyc(mk(1'b0, 1'b0), 1'b0, O_FRZ, "rst_wait1");
      cyc(mk(1'b0, 1'b0), 1'b0, O_FRZ, "rst_wait2");
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({a_pc, a_ifid, a_flush, a_idex, a_lock, a_start}), 32'(O_RST));
      chk("rst_mid_stall", 32'(a_stall), 32'd0);
      chk("rst_mid_err", 32'(a_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(mk(1'b0, 1'b0), 1'b0, O_IDLE, "rst_after_run");
      chk("rst_after_stall", 32'(a_stall), 32'd0);
      chk("rst_after_err", 32'(a_err), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
